// File: rtl/midi_pkg.sv
// Shared constants, FSM state type and status-byte decoding for the MIDI transmit path.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam int DEFAULT_CLKS_PER_BIT = 1600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } midi_state_t;

  // Number of data bytes that follow a status byte, 0 when the status is not a channel message.
  function automatic logic [1:0] data_byte_count(input logic [3:0] status_nibble);
    case (status_nibble)
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: data_byte_count = 2'd2;
      PROG, CHAN_AT:                         data_byte_count = 2'd1;
      default:                               data_byte_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_uart_tx_byte.sv
// 8N1 byte serializer; a load on the last cycle of a stop bit chains the next frame with no gap.
module midi_uart_tx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       busy,
  output logic       bit_done,
  output logic       bit_pre_done,
  output logic       stop_bit
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  midi_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;

  assign busy         = (state_reg != ST_IDLE);
  assign bit_done     = busy && (cnt_reg == CNT_LAST);
  assign bit_pre_done = busy && (cnt_reg == CNT_PRE);
  assign stop_bit     = (state_reg == ST_STOP);
  assign tx           = tx_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else if (load) begin
      // Start bit goes on the line from the very next cycle.
      state_reg <= ST_START;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= byte_in;
      tx_reg    <= 1'b0;
    end else if (busy) begin
      if (!bit_done) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
        case (state_reg)
          ST_START: begin
            state_reg <= ST_DATA;
            tx_reg    <= shift_reg[0];
          end
          ST_DATA: begin
            if (idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
              idx_reg   <= '0;
              tx_reg    <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx_reg    <= shift_reg[1];
            end
          end
          ST_STOP: begin
            state_reg <= ST_IDLE;
            tx_reg    <= 1'b1;
          end
          default: begin
            state_reg <= ST_IDLE;
            tx_reg    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI channel-message transmitter: validates, applies running status and sequences
// up to three bytes through the byte serializer.
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic        Clk,
  input  logic        clr,
  input  logic [7:0]  status,
  input  logic [15:0] data,
  input  logic        send,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic        tx_out
);

  // ST_LOAD marks a message in flight; the bit-level states live in the serializer.
  midi_state_t state_reg;
  logic        ready_reg;
  logic        done_reg;
  logic        err_reg;
  logic [7:0]  last_status_reg;
  logic [1:0]  byte_cnt_reg;
  logic [7:0]  queue_reg [2];

  logic [1:0]  msg_len;
  logic        send_status;
  logic        accept;
  logic        load;
  logic [7:0]  load_byte;
  logic        ser_busy;
  logic        ser_bit_done;
  logic        ser_bit_pre_done;
  logic        ser_stop_bit;
  logic        stop_end;
  logic        stop_pre_end;

  assign stop_end     = ser_stop_bit && ser_bit_done;
  assign stop_pre_end = ser_stop_bit && ser_bit_pre_done;
  assign accept       = send && ready_reg && !ser_busy;

  always_comb begin
    msg_len     = data_byte_count(status[7:4]);
    send_status = !(RUNNING_STATUS && (status == last_status_reg));
    load        = 1'b0;
    load_byte   = 8'h00;
    if (state_reg == ST_IDLE && accept && msg_len != 2'd0) begin
      load      = 1'b1;
      load_byte = send_status ? status : data[15:8];
    end else if (state_reg == ST_LOAD && stop_end && byte_cnt_reg > 2'd1) begin
      load      = 1'b1;
      load_byte = queue_reg[0];
    end
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      state_reg       <= ST_IDLE;
      ready_reg       <= 1'b1;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      last_status_reg <= 8'h00;
      byte_cnt_reg    <= 2'd0;
      queue_reg[0]    <= 8'h00;
      queue_reg[1]    <= 8'h00;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (msg_len == 2'd0) begin
              err_reg <= 1'b1;
            end else begin
              ready_reg <= 1'b0;
              state_reg <= ST_LOAD;
              if (send_status) begin
                last_status_reg <= status;
                queue_reg[0]    <= data[15:8];
                queue_reg[1]    <= data[7:0];
                byte_cnt_reg    <= msg_len + 2'd1;
              end else begin
                queue_reg[0]    <= data[7:0];
                queue_reg[1]    <= 8'h00;
                byte_cnt_reg    <= msg_len;
              end
            end
          end
        end
        ST_LOAD: begin
          // done must be visible during the final stop cycle, so it is set one cycle early.
          if (stop_pre_end && byte_cnt_reg == 2'd1) begin
            done_reg <= 1'b1;
          end
          if (stop_end) begin
            if (byte_cnt_reg > 2'd1) begin
              byte_cnt_reg <= byte_cnt_reg - 2'd1;
              queue_reg[0] <= queue_reg[1];
            end else begin
              byte_cnt_reg <= 2'd0;
              state_reg    <= ST_IDLE;
              ready_reg    <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  midi_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk         (Clk),
    .srst        (clr),
    .load        (load),
    .byte_in     (load_byte),
    .tx          (tx_out),
    .busy        (ser_busy),
    .bit_done    (ser_bit_done),
    .bit_pre_done(ser_bit_pre_done),
    .stop_bit    (ser_stop_bit)
  );

  assign ready = ready_reg;
  assign done  = done_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Scoreboard bench: a line monitor decodes 8N1 frames and compares them against
// bytes predicted from the MIDI message rules; the stimulus side checks timing.
module tb_midi_msg_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        send;
  logic [7:0]  status;
  logic [15:0] data;
  logic        ready;
  logic        done;
  logic        err;
  logic        tx_out;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  model_last = 8'h00;
  bit          trunc_flag = 1'b0;

  always #5 clk = ~clk;

  midi_msg_tx #(
    .CLKS_PER_BIT  (CPB),
    .RUNNING_STATUS(1'b1)
  ) dut (
    .Clk   (clk),
    .clr   (clr),
    .status(status),
    .data  (data),
    .send  (send),
    .ready (ready),
    .done  (done),
    .err   (err),
    .tx_out(tx_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Channel-message data length from the status byte; 0 for anything not transmittable.
  function automatic int model_len(input logic [7:0] s);
    if (s < 8'h80 || s >= 8'hF0) return 0;
    if (s >= 8'hC0 && s < 8'hE0) return 1;
    return 2;
  endfunction

  // Line monitor: samples each bit in its middle and scores complete frames.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    logic       start_b;
    logic       stop_b;
    forever begin
      @(negedge clk);
      if (tx_out === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        start_b = tx_out;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx_out;
        end
        repeat (CPB) @(negedge clk);
        stop_b = tx_out;
        if (trunc_flag) begin
          trunc_flag = 1'b0;
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%02h expected=none", b);
        end else begin
          e = exp_q.pop_front();
          check("line_byte", {24'h0, b}, {24'h0, e});
          check("framing", {30'h0, start_b, stop_b}, 32'h1);
        end
      end
    end
  end

  task automatic idle_window(input string name, input int cycles);
    int lows = 0;
    int dones = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
      if (done !== 1'b0) dones++;
    end
    check({name, "_tx_idle"}, lows, 0);
    check({name, "_no_done"}, dones, 0);
  endtask

  task automatic do_msg(input logic [7:0] st, input logic [15:0] d,
                        input int mid_send_at, input int clr_at);
    int n;
    int nb;
    int cyc;
    int rdy_bad;
    n = model_len(st);
    @(negedge clk);
    status = st;
    data   = d;
    send   = 1'b1;
    @(negedge clk);
    send = 1'b0;
    if (n == 0) begin
      check("err_pulse", err, 1);
      check("ready_after_err", ready, 1);
      @(negedge clk);
      check("err_one_cycle", err, 0);
      idle_window("reject", 3 * CPB);
      $display("msg status=%02h data=%04h rejected", st, d);
      return;
    end
    nb = n;
    if (st != model_last) begin
      exp_q.push_back(st);
      model_last = st;
      nb++;
    end
    exp_q.push_back(d[15:8]);
    if (n == 2) exp_q.push_back(d[7:0]);

    check("ready_low", ready, 0);
    cyc = 1;
    rdy_bad = 0;
    while (done !== 1'b1 && cyc < 500) begin
      if (clr_at != 0 && cyc == clr_at) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_q.delete();
        model_last = 8'h00;
        trunc_flag = 1'b1;
        check("clr_tx_idle", tx_out, 1);
        check("clr_ready", ready, 1);
        idle_window("after_clr", 12 * CPB);
        $display("msg status=%02h data=%04h cleared at cycle %0d", st, d, cyc);
        return;
      end
      send = (cyc == mid_send_at);
      if (send) begin
        status = 8'hB7;
        data   = 16'hA55A;
      end
      if (ready !== 1'b0) rdy_bad++;
      @(negedge clk);
      cyc++;
    end
    send = 1'b0;
    check("busy_cycles", cyc, nb * 10 * CPB);
    check("ready_during_busy", rdy_bad, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_back", ready, 1);
    check("queue_drained", exp_q.size(), 0);
    $display("msg status=%02h data=%04h bytes=%0d cycles=%0d", st, d, nb, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st;
    int sel;
    clr    = 1'b1;
    send   = 1'b0;
    status = 8'h00;
    data   = 16'h0000;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_tx", tx_out, 1);
    check("reset_done", done, 0);
    check("reset_err", err, 0);

    do_msg(8'h90, 16'h3C64, 0, 0);
    do_msg(8'h90, 16'h4000, 0, 0);
    do_msg(8'h80, 16'h3C00, 0, 0);
    do_msg(8'hC5, 16'h07FF, 0, 0);
    do_msg(8'h3C, 16'h1234, 0, 0);
    do_msg(8'hF8, 16'h1234, 0, 0);
    do_msg(8'hC5, 16'h0900, 0, 0);
    do_msg(8'hB2, 16'h0740, 30, 0);
    idle_window("post_mid_send", 20);
    do_msg(8'h90, 16'h1111, 0, 0);
    do_msg(8'h90, 16'h2222, 0, 55);
    do_msg(8'h90, 16'h3333, 0, 0);

    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      st = {4'(8 + sel), 4'($urandom_range(0, 1))};
      else if (sel == 7) st = 8'($urandom_range(0, 127));
      else if (sel == 8) st = {4'hF, 4'($urandom_range(0, 15))};
      else               st = (model_last != 8'h00) ? model_last : 8'h90;
      do_msg(st, 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 35)) : 0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    idle_window("final", 20);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
